// File: rtl/shot_clock_pkg.sv
// Shared types and helpers for the shot-clock controller.
package shot_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int DEF_FULL_SEC  = 24;
  localparam int DEF_SHORT_SEC = 14;

  // Binary value of a two-digit BCD number (0..99).
  function automatic logic [6:0] bcd_to_bin(input bcd_t tens, input bcd_t ones);
    return ({3'd0, tens} * 7'd10) + {3'd0, ones};
  endfunction

  // One-step BCD decrement; 00 saturates.
  function automatic logic [7:0] bcd_dec(input bcd_t tens, input bcd_t ones);
    logic [7:0] res;
    if (ones != 4'd0) begin
      res = {tens, ones - 4'd1};
    end else if (tens != 4'd0) begin
      res = {tens - 4'd1, 4'd9};
    end else begin
      res = 8'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/shot_clock_ctrl_tick_gen.sv
// Prescaler producing a one-second tick; counts only while run is high.
module tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Prescaler: clear wins, otherwise advance and wrap while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= (cnt_r == LAST) ? '0 : (cnt_r + ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = run & ~clr & (cnt_r == LAST);

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencing: FSM, BCD seconds register and expiry buzzer.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int BUZZ_CYCLES = 100_000_000,
  parameter int FULL_SEC    = DEF_FULL_SEC,
  parameter int SHORT_SEC   = DEF_SHORT_SEC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       reload_full,
  input  logic       reload_short,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       cnt_en,
  output logic       running,
  output logic       expired
);

  localparam bcd_t FULL_TENS  = 4'(FULL_SEC / 10);
  localparam bcd_t FULL_ONES  = 4'(FULL_SEC % 10);
  localparam bcd_t SHORT_TENS = 4'(SHORT_SEC / 10);
  localparam bcd_t SHORT_ONES = 4'(SHORT_SEC % 10);
  localparam int   BW         = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
  localparam logic [BW-1:0] BUZZ_ONE  = BW'(1);

  state_t          state_r, state_s;
  bcd_t            tens_r, ones_r, tens_s, ones_s;
  logic            running_r, expired_r;
  logic [BW-1:0]   buzz_r;
  logic            reload_s, short_ok_s, run_s, tick_s, cnt_en_s, at_one_s;
  logic [7:0]      dec_s;

  assign reload_s   = reload_full | reload_short;
  assign short_ok_s = (bcd_to_bin(tens_r, ones_r) < 7'(SHORT_SEC));
  // Pause freezes the prescaler in the cycle it arrives so the fraction survives.
  assign run_s      = (state_r == RUN) & ~pause;
  assign at_one_s   = (tens_r == 4'd0) & (ones_r == 4'd1);
  assign dec_s      = bcd_dec(tens_r, ones_r);

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_s),
    .clr   (reload_s),
    .tick  (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic with reload > pause > start > tick priority.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (reload_s)   state_s = IDLE;
        else if (pause) state_s = IDLE;
        else if (start) state_s = RUN;
        else            state_s = IDLE;
      end
      RUN: begin
        if (reload_s)                 state_s = RUN;
        else if (pause)               state_s = PAUSE;
        else if (cnt_en_s && at_one_s) state_s = EXPIRED;
        else                          state_s = RUN;
      end
      PAUSE: begin
        if (reload_s)   state_s = PAUSE;
        else if (pause) state_s = PAUSE;
        else if (start) state_s = RUN;
        else            state_s = PAUSE;
      end
      EXPIRED: begin
        if (reload_s) state_s = IDLE;
        else          state_s = EXPIRED;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output/datapath logic: decrement strobe and next digit values.
  always_comb begin
    cnt_en_s = tick_s & ((tens_r != 4'd0) | (ones_r != 4'd0));
    tens_s   = tens_r;
    ones_s   = ones_r;
    if (reload_full) begin
      tens_s = FULL_TENS;
      ones_s = FULL_ONES;
    end else if (reload_short && short_ok_s) begin
      tens_s = SHORT_TENS;
      ones_s = SHORT_ONES;
    end else if (cnt_en_s) begin
      tens_s = dec_s[7:4];
      ones_s = dec_s[3:0];
    end else begin
      tens_s = tens_r;
      ones_s = ones_r;
    end
  end

  // Seconds register and registered running flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_r    <= FULL_TENS;
      ones_r    <= FULL_ONES;
      running_r <= 1'b0;
    end else begin
      tens_r    <= tens_s;
      ones_r    <= ones_s;
      running_r <= (state_s == RUN);
    end
  end

  // Buzzer: raised on entering EXPIRED, dropped after BUZZ_CYCLES or on reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired_r <= 1'b0;
      buzz_r    <= '0;
    end else if ((state_r == EXPIRED) && reload_s) begin
      expired_r <= 1'b0;
      buzz_r    <= '0;
    end else if ((state_r != EXPIRED) && (state_s == EXPIRED)) begin
      expired_r <= 1'b1;
      buzz_r    <= '0;
    end else if (expired_r) begin
      if (buzz_r == BUZZ_LAST) begin
        expired_r <= 1'b0;
      end else begin
        buzz_r <= buzz_r + BUZZ_ONE;
      end
    end else begin
      expired_r <= expired_r;
    end
  end

  assign sec_tens = tens_r;
  assign sec_ones = ones_r;
  assign cnt_en   = cnt_en_s;
  assign running  = running_r;
  assign expired  = expired_r;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Self-checking bench for shot_clock_ctrl with a seconds-level reference model.
module tb_shot_clock_ctrl;

  localparam int TICK  = 4;
  localparam int BUZZ  = 3;
  localparam int FULL  = 24;
  localparam int SHORT = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, reload_full = 1'b0, reload_short = 1'b0;
  logic [3:0] sec_tens, sec_ones;
  logic       cnt_en, running, expired;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining seconds, cycles elapsed in the current second,
  // whether the clock is counting, whether it has run out, buzzer cycles left.
  int m_secs, m_elapsed, m_buzz;
  bit m_run, m_done;

  logic obs_cnt_en, obs_exp;
  int   n_ticks, n_exp, first_tick, acc;

  shot_clock_ctrl #(
    .TICK_CYCLES(TICK), .BUZZ_CYCLES(BUZZ), .FULL_SEC(FULL), .SHORT_SEC(SHORT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .reload_full(reload_full), .reload_short(reload_short),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .cnt_en(cnt_en), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs = FULL; m_elapsed = 0; m_buzz = 0; m_run = 1'b0; m_done = 1'b0;
  endtask

  function automatic bit model_tick(input bit p, input bit rf, input bit rs);
    return m_run && !p && !rf && !rs && (m_elapsed == TICK - 1) && (m_secs > 0);
  endfunction

  task automatic model_step(input bit s, input bit p, input bit rf, input bit rs);
    bit t;
    t = model_tick(p, rf, rs);
    if (m_buzz > 0) m_buzz--;
    if (rf || rs) begin
      if (rf) m_secs = FULL;
      else if (m_secs < SHORT) m_secs = SHORT;
      m_elapsed = 0;
      if (m_done) begin
        m_done = 1'b0;
        m_buzz = 0;
      end
    end else if (p) begin
      m_run = 1'b0;
    end else if (m_run) begin
      m_elapsed = (m_elapsed + 1) % TICK;
      if (t) begin
        m_secs--;
        if (m_secs == 0) begin
          m_run = 1'b0; m_done = 1'b1; m_buzz = BUZZ;
        end
      end
    end else if (s && !m_done) begin
      m_run = 1'b1;
    end
  endtask

  // One clock: drive at the falling edge, compare, then advance the model.
  task automatic cycle(input bit s, input bit p, input bit rf, input bit rs);
    start = s; pause = p; reload_full = rf; reload_short = rs;
    #1;
    chk("tens",    int'(sec_tens), m_secs / 10);
    chk("ones",    int'(sec_ones), m_secs % 10);
    chk("cnt_en",  int'(cnt_en),   int'(model_tick(p, rf, rs)));
    chk("running", int'(running),  int'(m_run));
    chk("expired", int'(expired),  int'(m_buzz > 0));
    obs_cnt_en = cnt_en;
    obs_exp    = expired;
    @(posedge clk);
    model_step(s, p, rf, rs);
    @(negedge clk);
    start = 1'b0; pause = 1'b0; reload_full = 1'b0; reload_short = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tens", int'(sec_tens), 2);
    chk("rst_ones", int'(sec_ones), 4);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_expired", int'(expired), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full countdown 24 -> 00 and buzzer.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n_ticks = 0; n_exp = 0; first_tick = -1;
    for (int i = 1; i <= 102; i++) begin
      idle(1);
      if (obs_cnt_en) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
      if (obs_exp) n_exp++;
    end
    chk("first_tick_cycle", first_tick, 4);
    chk("tick_count", n_ticks, 24);
    chk("expired_cycles", n_exp, 3);
    chk("end_tens", int'(sec_tens), 0);
    chk("end_ones", int'(sec_ones), 0);
    chk("end_running", int'(running), 0);

    // Expired: start ignored, reload_full returns to IDLE at 24.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("exp_start_ignored", int'(running), 0);
    chk("exp_hold_ones", int'(sec_ones), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("exp_reload_tens", int'(sec_tens), 2);
    chk("exp_reload_ones", int'(sec_ones), 4);
    chk("exp_reload_expired", int'(expired), 0);
    chk("exp_reload_running", int'(running), 0);
    idle(2);

    // Pause at prescaler 2 for 10 cycles, resume -> tick 2 cycles later.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      acc += int'(obs_cnt_en);
    end
    chk("paused_no_tick", acc, 0);
    chk("paused_running", int'(running), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("resume_c1", int'(obs_cnt_en), 0);
    idle(1);
    chk("resume_c2", int'(obs_cnt_en), 1);
    chk("resume_ones", int'(sec_ones), 3);

    // reload_short ignored at 20, applied at 09 with prescaler clear.
    idle(12);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("short20_tens", int'(sec_tens), 2);
    chk("short20_ones", int'(sec_ones), 0);
    idle(44);
    chk("at09_tens", int'(sec_tens), 0);
    chk("at09_ones", int'(sec_ones), 9);
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("short09_tens", int'(sec_tens), 1);
    chk("short09_ones", int'(sec_ones), 4);
    chk("short09_running", int'(running), 1);
    idle(3);
    chk("short_clr_c3", int'(obs_cnt_en), 0);
    idle(1);
    chk("short_clr_c4", int'(obs_cnt_en), 1);

    // reload_full + pause coinciding with a tick at 15.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(36);
    chk("at15_ones", int'(sec_ones), 5);
    idle(3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rf_pause_tick", int'(obs_cnt_en), 0);
    chk("rf_pause_tens", int'(sec_tens), 2);
    chk("rf_pause_ones", int'(sec_ones), 4);
    chk("rf_pause_running", int'(running), 1);

    // Asynchronous reset at 11 while a tick is pending.
    idle(52);
    idle(3);
    #1;
    chk("pre_rst_tens", int'(sec_tens), 1);
    chk("pre_rst_ones", int'(sec_ones), 1);
    chk("pre_rst_cnt_en", int'(cnt_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tens", int'(sec_tens), 2);
    chk("arst_ones", int'(sec_ones), 4);
    chk("arst_cnt_en", int'(cnt_en), 0);
    chk("arst_running", int'(running), 0);
    chk("arst_expired", int'(expired), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk("post_rst_idle", int'(running), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("restart_ones", int'(sec_ones), 3);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shot_clock_ctrl.md
# shot_clock_ctrl

Sequencing controller for the 24-second shot-clock countdown. It generates the one-second tick, decides when the BCD seconds register decrements, and applies start, pause and reload commands. It also drives the expiry buzzer. It sits between the debounced push-button pulses and the seven-segment display driver.

## Interface
- `TICK_CYCLES`, 50_000_000: clk cycles per one-second tick (≥2)
- `BUZZ_CYCLES`, 100_000_000: cycles `expired` stays high after reaching 00 (≥1)
- `FULL_SEC`, 24: full reload value (BCD-representable, 1..99)
- `SHORT_SEC`, 14: short reload value (1..`FULL_SEC`)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  single-cycle pulse: start/resume countdown
- `pause`  in  1  single-cycle pulse: freeze countdown
- `reload_full`  in  1  single-cycle pulse: load `FULL_SEC`
- `reload_short`  in  1  single-cycle pulse: load `SHORT_SEC` only if current count < `SHORT_SEC`
- `sec_tens`  out  4  BCD tens digit
- `sec_ones`  out  4  BCD ones digit
- `cnt_en`  out  1  decrement strobe, high in the cycle whose edge decrements the count
- `running`  out  1  high in RUN
- `expired`  out  1  buzzer drive

## Operation
- One clock and one reset. Reset is asynchronous and active-low, and release is synchronous to `clk`. Inputs are synchronous, already-debounced single-cycle pulses.
- Reset values:
  - state IDLE
  - `sec_tens`=`FULL_SEC`/10, `sec_ones`=`FULL_SEC`%10
  - `cnt_en`=0, `running`=0, `expired`=0
  - prescaler=0, buzz counter=0
- Command priority within one cycle: `reload_full` > `reload_short` > `pause` > `start` > tick.
- States:
  - IDLE: `start` → RUN. Reload loads the value and stays in IDLE.
  - RUN: tick decrements the count. A decrement from 01 to 00 → EXPIRED. `pause` → PAUSE. Reload loads the value, clears the prescaler and stays in RUN.
  - PAUSE: `start` → RUN with the prescaler retained. Reload loads the value, clears the prescaler and stays in PAUSE.
  - EXPIRED: count holds 00 and `start`/`pause` are ignored. Any reload loads the value, clears `expired` and the buzz counter, and goes to IDLE.
- `reload_short` with count ≥ `SHORT_SEC` changes neither the count nor the state. It still clears the prescaler in RUN/PAUSE, and still exits EXPIRED (count is 00 there, so 14 is loaded).
- Prescaler: counts only in RUN, range 0..`TICK_CYCLES`-1, and wraps. Tick = RUN & prescaler==`TICK_CYCLES`-1 & no higher-priority command.
- `cnt_en` = tick, combinational from registered state.
- BCD decrement:
  - ones>0 → ones-1
  - ones==0 → ones=9, tens-1
  - 00 never decrements
- `expired`: set on the edge entering EXPIRED. The buzz counter then runs, and `expired` clears after `BUZZ_CYCLES` high cycles. The state stays EXPIRED until a reload.
- `running` = (state==RUN), registered.

## Timing
- `start` sampled at edge N: `running`=1 after edge N.
- First `cnt_en` appears `TICK_CYCLES` cycles after RUN entry. The digits change on the edge ending the `cnt_en` cycle.
- Full countdown from RUN entry to `expired`=1 takes `FULL_SEC`×`TICK_CYCLES` cycles.
- Pause then resume: the remaining fraction of the current second is preserved.
- `pause` and tick in the same cycle: no decrement.
- Reload and tick in the same cycle: loaded value wins, no decrement.
- Reset asserted mid-count: all outputs return to reset values immediately, independent of `clk`.

## Structure
- Shared package `shot_clock_pkg`:
  - state enum {IDLE, RUN, PAUSE, EXPIRED}
  - BCD digit typedef
  - default `FULL_SEC`/`SHORT_SEC` constants
- Sub-module `tick_gen`: prescaler with `run` and `clr` inputs and a `tick` output, parameterised by `TICK_CYCLES`.
- Seconds register, FSM and buzz counter live in the top level.

## Test plan
Bench parameters: `TICK_CYCLES`=4, `BUZZ_CYCLES`=3.
- Reset, then `start` and run → digits 24, 23, … 00, with `cnt_en` every 4 cycles. `expired` goes high on reaching 00 and is high for exactly 3 cycles. `running`=0 afterwards.
- Start, let the prescaler reach 2, `pause` for 10 cycles, then `start` → next decrement 2 cycles after resume. No `cnt_en` while paused.
- Count at 20, `reload_short` → count stays 20. Count at 09, `reload_short` → 14, state unchanged, prescaler cleared.
- `reload_full` and `pause` in the same cycle as a tick at count 15 → count 24, no decrement, state RUN.
- In EXPIRED, `start` → ignored. `reload_full` → count 24, IDLE, `expired`=0.
- `rst_n` low mid-count at 11 in RUN → immediately 24, IDLE, all strobes 0. After release, resumes only on `start`.
